// File: rtl/pipe_if_defs.sv
// Shared defaults for the prefetching fetch stage.
// A queue entry is laid out as {pc, inst}.
package pipe_if_defs;
  localparam int          XLEN_D     = 32;
  localparam int          INC_D      = 4;
  localparam logic [31:0] RESET_PC_D = 32'h0000_0000;
  localparam int          ENTRY_W    = 2 * XLEN_D;
endpackage

// File: rtl/pipe_if_queue.sv
// Synchronous DEPTH-entry FIFO holding fetched {pc, inst} pairs.
// Flush has priority over push and pop.
module pipe_if_queue
  import pipe_if_defs::*;
#(
  parameter int W     = ENTRY_W,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       i_clr,
  input  logic                       i_flush,
  input  logic                       i_push,
  input  logic [W-1:0]               i_push_data,
  input  logic                       i_pop,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic [W-1:0]               o_head,
  output logic                       o_valid
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_rd, r_wr;
  logic [CW-1:0] r_count;

  always_ff @(posedge clk) begin
    if (i_clr || i_flush) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr] <= i_push_data;
        r_wr        <= r_wr + 1'b1;
      end
      if (i_pop) r_rd <= r_rd + 1'b1;
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_rd];
  assign o_valid = (r_count != '0);
endmodule

// File: rtl/pipe_if_prefetch.sv
// Instruction fetch stage: PC register, 1-cycle-latency memory issue,
// prefetch queue with valid/ready hand-off to ID, redirect flush.
module pipe_if_prefetch
  import pipe_if_defs::*;
#(
  parameter int              XLEN     = XLEN_D,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_D,
  parameter int              INC      = INC_D
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     redirect,
  input  logic [XLEN-1:0]          redirect_pc,
  output logic                     imem_req,
  output logic [XLEN-1:0]          imem_addr,
  input  logic [XLEN-1:0]          imem_rdata,
  input  logic                     id_ready,
  output logic                     if_valid,
  output logic [XLEN-1:0]          inst,
  output logic [XLEN-1:0]          pc,
  output logic [XLEN-1:0]          p4,
  output logic [$clog2(DEPTH):0]   q_count
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0]   r_fetch_pc;
  logic              r_inflight;
  logic [XLEN-1:0]   r_inflight_pc;
  logic              w_pop;
  logic              w_push;
  logic [CW:0]       w_need;
  logic [2*XLEN-1:0] w_head;

  // Slots already taken plus the reservation held by an outstanding read.
  assign w_pop    = if_valid && id_ready;
  assign w_need   = {1'b0, q_count} - (CW+1)'(w_pop) + (CW+1)'(r_inflight);
  assign imem_req = !clr && !redirect && (w_need < (CW+1)'(DEPTH));
  assign imem_addr = r_fetch_pc;

  // A redirect flushes the queue, which also drops the returning response.
  assign w_push = r_inflight && !redirect;

  always_ff @(posedge clk) begin
    if (clr) begin
      r_fetch_pc    <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= RESET_PC;
    end else if (redirect) begin
      r_fetch_pc <= redirect_pc;
      r_inflight <= 1'b0;
    end else if (imem_req) begin
      r_fetch_pc    <= r_fetch_pc + XLEN'(INC);
      r_inflight    <= 1'b1;
      r_inflight_pc <= r_fetch_pc;
    end else begin
      r_inflight <= 1'b0;
    end
  end

  pipe_if_queue #(.W(2*XLEN), .DEPTH(DEPTH)) u_queue (
    .clk         (clk),
    .i_clr       (clr),
    .i_flush     (redirect),
    .i_push      (w_push),
    .i_push_data ({r_inflight_pc, imem_rdata}),
    .i_pop       (w_pop),
    .o_count     (q_count),
    .o_head      (w_head),
    .o_valid     (if_valid)
  );

  assign inst = w_head[XLEN-1:0];
  assign pc   = w_head[2*XLEN-1:XLEN];
  assign p4   = pc + XLEN'(INC);
endmodule

// File: tb/tb_pipe_if_prefetch.sv
// Directed bench for pipe_if_prefetch: memory model returns addr^A5A5A5A5.
module tb_pipe_if_prefetch;
  localparam logic [31:0] KEY = 32'hA5A5_A5A5;

  logic        clk = 1'b0;
  logic        clr, redirect, id_ready;
  logic [31:0] redirect_pc, imem_addr, imem_rdata, inst, pc, p4;
  logic        imem_req, if_valid;
  logic [2:0]  q_count;

  logic        w_clr, w_ready;
  logic [31:0] w_addr, w_rdata, w_inst, w_pc, w_p4;
  logic        w_req, w_valid;
  logic [2:0]  w_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipe_if_prefetch u_dut (
    .clk(clk), .clr(clr), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .id_ready(id_ready), .if_valid(if_valid), .inst(inst), .pc(pc), .p4(p4),
    .q_count(q_count)
  );

  pipe_if_prefetch #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk(clk), .clr(w_clr), .redirect(1'b0), .redirect_pc(32'h0),
    .imem_req(w_req), .imem_addr(w_addr), .imem_rdata(w_rdata),
    .id_ready(w_ready), .if_valid(w_valid), .inst(w_inst), .pc(w_pc), .p4(w_p4),
    .q_count(w_count)
  );

  always @(posedge clk) begin
    if (imem_req) imem_rdata <= imem_addr ^ KEY;
    if (w_req)    w_rdata    <= w_addr ^ KEY;
  end

  typedef struct {
    logic        c, r;
    logic [31:0] rpc;
    logic        rdy;
    logic        ereq;
    logic [31:0] eaddr;
    logic        ev;
    logic [31:0] epc;
    int          ecnt;
  } vec_t;

  task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s %s: got %h want %h", nm, fld, act, exp);
    end
  endtask

  // Apply one cycle of inputs, check the combinational view, then clock.
  task automatic cyc(input string nm, input vec_t v);
    clr = v.c; redirect = v.r; redirect_pc = v.rpc; id_ready = v.rdy;
    #1;
    chk(nm, "imem_req", 32'(imem_req), 32'(v.ereq));
    if (v.ereq) chk(nm, "imem_addr", imem_addr, v.eaddr);
    chk(nm, "if_valid", 32'(if_valid), 32'(v.ev));
    if (v.ev) begin
      chk(nm, "pc", pc, v.epc);
      chk(nm, "inst", inst, v.epc ^ KEY);
      chk(nm, "p4", p4, v.epc + 32'd4);
    end
    chk(nm, "q_count", 32'(q_count), 32'(v.ecnt));
    @(posedge clk); #1;
  endtask

  vec_t tv[$];

  initial begin
    clr = 1'b1; redirect = 1'b0; redirect_pc = '0; id_ready = 1'b0;
    w_clr = 1'b1; w_ready = 1'b1;
    @(posedge clk); #1;

    // PC wrap across 2^32 on the second instance
    w_clr = 1'b0; #1;
    chk("wrap0", "req", 32'(w_req), 32'd1);
    chk("wrap0", "addr", w_addr, 32'hFFFF_FFF8);
    @(posedge clk); #2;
    chk("wrap1", "addr", w_addr, 32'hFFFF_FFFC);
    @(posedge clk); #2;
    chk("wrap2", "addr", w_addr, 32'h0000_0000);
    chk("wrap2", "pc", w_pc, 32'hFFFF_FFF8);
    chk("wrap2", "p4", w_p4, 32'hFFFF_FFFC);
    @(posedge clk); #2;
    chk("wrap3", "pc", w_pc, 32'hFFFF_FFFC);
    chk("wrap3", "p4", w_p4, 32'h0000_0000);
    chk("wrap3", "inst", w_inst, 32'hFFFF_FFFC ^ KEY);
    w_clr = 1'b1;
    @(posedge clk); #1;

    // streaming with id_ready=1 from reset
    tv.push_back('{1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0, 0});
    tv.push_back('{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0,  1'b0, 32'h0, 0});
    tv.push_back('{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h4,  1'b0, 32'h0, 0});
    tv.push_back('{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h8,  1'b1, 32'h0, 1});
    tv.push_back('{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'hC,  1'b1, 32'h4, 1});
    tv.push_back('{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h10, 1'b1, 32'h8, 1});
    // mid-stream clr, then id_ready=0 until the queue fills
    tv.push_back('{1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0,  1'b1, 32'hC, 1});
    tv.push_back('{1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0,  1'b0, 32'h0, 0});
    tv.push_back('{1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h4,  1'b0, 32'h0, 0});
    tv.push_back('{1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h8,  1'b1, 32'h0, 1});
    tv.push_back('{1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hC,  1'b1, 32'h0, 2});
    tv.push_back('{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0,  1'b1, 32'h0, 3});
    tv.push_back('{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0,  1'b1, 32'h0, 4});
    tv.push_back('{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h10, 1'b1, 32'h0, 4});
    tv.push_back('{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h14, 1'b1, 32'h4, 3});
    foreach (tv[i]) cyc($sformatf("vec%0d", i), tv[i]);

    // redirect with 3 queued (8,C,10) and the fetch of 0x14 in flight
    cyc("rd0",  '{1'b0, 1'b1, 32'h100, 1'b1, 1'b0, 32'h0,   1'b1, 32'h8,   3});
    cyc("rd1",  '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h100, 1'b0, 32'h0,   0});
    cyc("rd2",  '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h104, 1'b0, 32'h0,   0});
    cyc("rd3",  '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h108, 1'b1, 32'h100, 1});
    // back-to-back redirects: 0x40 must never reach the head
    cyc("dbl0", '{1'b0, 1'b1, 32'h40,  1'b1, 1'b0, 32'h0,   1'b1, 32'h100, 2});
    cyc("dbl1", '{1'b0, 1'b1, 32'h80,  1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   0});
    cyc("dbl2", '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h80,  1'b0, 32'h0,   0});
    cyc("dbl3", '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h84,  1'b0, 32'h0,   0});
    cyc("dbl4", '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h88,  1'b1, 32'h80,  1});
    // clr beats redirect and id_ready in the same cycle
    cyc("cr0",  '{1'b1, 1'b1, 32'h200, 1'b1, 1'b0, 32'h0,   1'b1, 32'h84,  1});
    cyc("cr1",  '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h0,   1'b0, 32'h0,   0});
    cyc("cr2",  '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h4,   1'b0, 32'h0,   0});
    cyc("cr3",  '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h8,   1'b1, 32'h0,   1});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
